// File: rtl/fir_pkg.sv
// Shared FIR datapath widths and sample types used by the adder tree, coefficient ROM and
// output requantizer.
package fir_pkg;

    localparam int unsigned FIR_IN_W  = 32;
    localparam int unsigned FIR_OUT_W = 16;
    localparam int unsigned FIR_SHIFT = 15;

    typedef logic signed [FIR_IN_W-1:0]  acc_t;
    typedef logic signed [FIR_OUT_W-1:0] sample_t;

    localparam sample_t OUT_MAX = sample_t'({1'b0, {(FIR_OUT_W-1){1'b1}}});
    localparam sample_t OUT_MIN = sample_t'({1'b1, {(FIR_OUT_W-1){1'b0}}});

endpackage

// File: rtl/requant_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of an accumulator sum
// down to the output sample width.
module requant_round_sat
    import fir_pkg::*;
#(
    parameter int unsigned IN_W  = FIR_IN_W,
    parameter int unsigned OUT_W = FIR_OUT_W,
    parameter int unsigned SHIFT = FIR_SHIFT
) (
    input  logic signed [IN_W-1:0]  acc_i,
    output logic signed [OUT_W-1:0] sample_o,
    output logic                    sat_o
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam logic signed [IN_W:0] HALF    = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAX_EXT = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_EXT = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] shr;

    always_comb begin
        ext = {acc_i[IN_W-1], acc_i};
        rnd = ext + HALF;
        shr = rnd >>> SHIFT;
        if (shr > MAX_EXT) begin
            sample_o = {1'b0, {(OUT_W-1){1'b1}}};
            sat_o    = 1'b1;
        end else if (shr < MIN_EXT) begin
            sample_o = {1'b1, {(OUT_W-1){1'b0}}};
            sat_o    = 1'b1;
        end else begin
            sample_o = shr[OUT_W-1:0];
            sat_o    = 1'b0;
        end
    end

endmodule

// File: rtl/fir_output_requantizer.sv
// FIR output stage: requantizes the accumulator sum into a 2-entry output FIFO and keeps
// sticky saturation statistics for debug.
module fir_output_requantizer
    import fir_pkg::*;
#(
    parameter int unsigned IN_W  = FIR_IN_W,
    parameter int unsigned OUT_W = FIR_OUT_W,
    parameter int unsigned SHIFT = FIR_SHIFT,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    input  logic                    clear_stats,
    output logic                    sat_flag,
    output logic [CNT_W-1:0]        sat_count
);

    logic signed [OUT_W-1:0] rq_sample;
    logic                    rq_sat;

    requant_round_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc_i    (in_data),
        .sample_o (rq_sample),
        .sat_o    (rq_sat)
    );

    logic signed [OUT_W-1:0] mem_q [2];
    logic signed [OUT_W-1:0] mem_d [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    sat_flag_q, sat_flag_d;
    logic [CNT_W-1:0]        sat_count_q, sat_count_d;
    logic                    push, pop, sat_ev;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;

    assign push   = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign sat_ev = push & rq_sat;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = rq_sample;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // A clear coinciding with a saturating push leaves exactly that one event counted.
    always_comb begin
        sat_flag_d  = sat_flag_q;
        sat_count_d = sat_count_q;
        if (clear_stats) begin
            sat_flag_d  = sat_ev;
            sat_count_d = {{(CNT_W-1){1'b0}}, sat_ev};
        end else if (sat_ev) begin
            sat_flag_d = 1'b1;
            if (sat_count_q != {CNT_W{1'b1}}) begin
                sat_count_d = sat_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            sat_flag_q  <= sat_flag_d;
            sat_count_q <= sat_count_d;
        end
    end

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Scoreboard bench for the FIR output requantizer: random and directed samples against a
// plain-arithmetic reference model.
module tb_fir_output_requantizer;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned SHIFT = 15;
    localparam int unsigned CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              clear_stats = 1'b0;
    logic              sat_flag;
    logic [CNT_W-1:0]  sat_count;

    fir_output_requantizer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .clear_stats (clear_stats),
        .sat_flag    (sat_flag),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stalls = 0;
    int n_out = 0;
    logic [OUT_W-1:0] sb_q[$];
    longint m_cnt = 0;
    bit     m_flag = 1'b0;
    bit     prev_push = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: floor((x + 2^(S-1)) / 2^S), then clamp to the signed output range.
    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] x, output bit sat);
        longint v, num, den, q, lim_hi, lim_lo;
        logic [63:0] r;
        v      = longint'($signed(x));
        den    = longint'(1) << SHIFT;
        num    = v + den / 2;
        q      = num / den;
        if (num < 0 && (num % den) != 0) q = q - 1;
        lim_hi = (longint'(1) << (OUT_W - 1)) - 1;
        lim_lo = -(longint'(1) << (OUT_W - 1));
        sat    = 1'b0;
        if (q > lim_hi) begin q = lim_hi; sat = 1'b1; end
        if (q < lim_lo) begin q = lim_lo; sat = 1'b1; end
        r = q;
        return r[OUT_W-1:0];
    endfunction

    // Monitor/scoreboard, sampled on the falling edge.
    initial begin
        logic [OUT_W-1:0] exp_d;
        bit push, s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                m_cnt = 0;
                m_flag = 1'b0;
                prev_push = 1'b0;
            end else begin
                chk("sat_count", longint'(sat_count), m_cnt);
                chk("sat_flag", longint'(sat_flag), longint'(m_flag));
                if (prev_push) chk("latency_out_valid", longint'(out_valid), 1);
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", longint'(out_data), -1);
                    end else begin
                        exp_d = sb_q.pop_front();
                        chk("out_data", longint'(out_data), longint'(exp_d));
                    end
                end
                push = in_valid && in_ready;
                s = 1'b0;
                if (push) sb_q.push_back(model(in_data, s));
                if (clear_stats) begin
                    m_cnt  = (push && s) ? 1 : 0;
                    m_flag = push && s;
                end else if (push && s) begin
                    m_flag = 1'b1;
                    if (m_cnt < (longint'(1) << CNT_W) - 1) m_cnt = m_cnt + 1;
                end
                prev_push = push;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that pushed x.
    task automatic send(input logic [IN_W-1:0] x);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        if (!in_ready) stalls++;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", longint'(sb_q.size()), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [IN_W-1:0]  rnd_in  [5] = '{32'h0000_8000, 32'h0000_4000, 32'h0000_3FFF,
                                      32'hFFFF_C000, 32'hFFFF_8000};
    logic [OUT_W-1:0] rnd_out [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF};

    initial begin
        logic [IN_W-1:0]  x;
        logic [OUT_W-1:0] e;
        bit s;
        int sel;

        #12;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_sat_count", longint'(sat_count), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Rounding vectors.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(rnd_in[i]);
            chk("round_valid", longint'(out_valid), 1);
            chk("round_data", longint'(out_data), longint'(rnd_out[i]));
        end
        idle(1);
        chk("round_sat_count", longint'(sat_count), 0);

        // Saturation both ways.
        send(32'h7FFF_FFFF);
        chk("sat_pos", longint'(out_data), 16'h7FFF);
        send(32'h8000_0000);
        chk("sat_neg", longint'(out_data), 16'h8000);
        idle(1);
        chk("sat_flag_set", longint'(sat_flag), 1);
        chk("sat_count_2", longint'(sat_count), 2);
        clear_stats = 1'b1;
        idle(1);
        clear_stats = 1'b0;
        chk("clear_flag", longint'(sat_flag), 0);
        chk("clear_count", longint'(sat_count), 0);

        // Backpressure: A, B fill the buffer, C must wait.
        out_ready = 1'b0;
        send(32'h0001_0000);
        send(32'hFFFE_0000);
        chk("bp_in_ready_full", longint'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = 32'h0003_0000;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready_held", longint'(in_ready), 0);
            chk("bp_out_valid_held", longint'(out_valid), 1);
        end
        out_ready = 1'b1;
        send(32'h0003_0000);
        wait_drain();

        // Streaming random samples.
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: x = $urandom;
                1: x = IN_W'($urandom_range(0, 32'h1FFFF)) - 32'h0001_0000;
                2: x = ($urandom_range(0, 1) != 0) ? 32'h3FFF_C000 + $urandom_range(0, 32'h7FFF)
                                                   : 32'hC000_0000 - $urandom_range(0, 32'h7FFF);
                default: x = (IN_W'($urandom_range(0, 32'hFFFF)) << SHIFT) + 32'h0000_4000;
            endcase
            send(x);
        end
        chk("stream_no_stall", longint'(stalls), 0);
        wait_drain();

        // Clear coinciding with a saturating push.
        clear_stats = 1'b1;
        idle(1);
        clear_stats = 1'b0;
        repeat (5) send(32'h7FFF_FFFF);
        idle(1);
        chk("pre_clear_count5", longint'(sat_count), 5);
        clear_stats = 1'b1;
        send(32'h7FFF_FFFF);
        clear_stats = 1'b0;
        chk("clr_push_count", longint'(sat_count), 1);
        chk("clr_push_flag", longint'(sat_flag), 1);
        wait_drain();

        // Asynchronous reset with two samples buffered.
        out_ready = 1'b0;
        send(32'h7FFF_FFFF);
        send(32'h0001_0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_in_ready", longint'(in_ready), 1);
        chk("arst_sat_count", longint'(sat_count), 0);
        chk("arst_sat_flag", longint'(sat_flag), 0);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(1);
        out_ready = 1'b1;
        x = 32'h0002_8000;
        e = model(x, s);
        send(x);
        chk("post_rst_valid", longint'(out_valid), 1);
        chk("post_rst_data", longint'(out_data), longint'(e));
        wait_drain();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
